// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with start-glitch rejection,
// mid-bit sampling, stop-bit check and FIFO overrun reporting.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  input  logic       fifo_full,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_error_q, frame_error_d;
  logic            overrun_q, overrun_d;

  assign rx_s = sync_q[1];

  // two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_serial};
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (clk_cnt_q == CNT_HALF)
                 state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (clk_cnt_q == CNT_LAST && bit_idx_q == 3'd7)
                 state_d = S_STOP;
      S_STOP:  if (clk_cnt_q == CNT_LAST)
                 state_d = rx_s ? S_IDLE : S_WAIT;
      S_WAIT:  if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // counters, shift register and output pulses
  always_comb begin
    clk_cnt_d     = clk_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    rx_byte_d     = rx_byte_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    case (state_q)
      S_START: begin
        if (clk_cnt_q == CNT_HALF) clk_cnt_d = '0;
        else                       clk_cnt_d = clk_cnt_q + 1'b1;
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          shift_d[bit_idx_q] = rx_s;
          clk_cnt_d          = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = fifo_full;
          end else begin
            frame_error_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_byte     = rx_byte_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Expected bytes are queued as frames are sent and popped on rx_valid.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_serial = 1'b1;
  logic       fifo_full = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .fifo_full  (fifo_full),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       o;
  } exp_t;

  exp_t exp_q[$];
  int   vcyc_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   valid_cnt = 0;
  int   fe_cnt = 0;
  int   ovr_cnt = 0;
  int   last_valid_cyc = -1;
  int   last_fe_cyc = -1;
  int   busy_rise_cyc = -1;
  int   busy_fall_cyc = -1;
  int   frame_c0 = 0;
  logic busy_prev = 1'b0;

  // monitor: pops the scoreboard on every rx_valid
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1 && busy_prev === 1'b0) busy_rise_cyc = cyc;
    if (busy === 1'b0 && busy_prev === 1'b1) busy_fall_cyc = cyc;
    busy_prev = busy;
    if (overrun === 1'b1) ovr_cnt++;
    if (frame_error === 1'b1) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      vcyc_q.push_back(cyc);
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected got byte=%h", rx_byte);
      end else begin
        e = exp_q.pop_front();
        if (rx_byte !== e.b || overrun !== e.o)
          $display("FAIL sb_byte got=%h/ovr=%b exp=%h/ovr=%b",
                   rx_byte, overrun, e.b, e.o);
        else pass_cnt++;
      end
    end
  end

  // drives one frame starting at the current falling edge
  task automatic send_frame(input logic [7:0] d, input logic stop);
    frame_c0 = cyc;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_serial = d[k];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if ({rx_valid, frame_error, overrun, busy} !== 4'b0000)
      $display("FAIL reset_pulses got=%b exp=0000",
               {rx_valid, frame_error, overrun, busy});
    else pass_cnt++;
    total_cnt++;
    if (rx_byte !== 8'h00)
      $display("FAIL reset_byte got=%h exp=00", rx_byte);
    else pass_cnt++;
    idle(5);
  endtask

  task automatic test_single_byte;
    int v0, f0, o0;
    v0 = valid_cnt; f0 = fe_cnt; o0 = ovr_cnt;
    exp_q.push_back('{8'hA5, 1'b0});
    send_frame(8'hA5, 1'b1);
    idle(20);
    total_cnt++;
    if (valid_cnt !== v0 + 1)
      $display("FAIL single_count got=%0d exp=%0d", valid_cnt, v0 + 1);
    else pass_cnt++;
    total_cnt++;
    if (last_valid_cyc !== frame_c0 + 155)
      $display("FAIL single_time got=%0d exp=%0d",
               last_valid_cyc, frame_c0 + 155);
    else pass_cnt++;
    total_cnt++;
    if (fe_cnt !== f0 || ovr_cnt !== o0)
      $display("FAIL single_flags got fe=%0d ovr=%0d exp fe=%0d ovr=%0d",
               fe_cnt, ovr_cnt, f0, o0);
    else pass_cnt++;
    total_cnt++;
    if (busy_rise_cyc !== frame_c0 + 3 || busy_fall_cyc !== frame_c0 + 155)
      $display("FAIL single_busy got=%0d..%0d exp=%0d..%0d",
               busy_rise_cyc, busy_fall_cyc, frame_c0 + 3, frame_c0 + 155);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    int v0, f0, c0;
    v0 = valid_cnt; f0 = fe_cnt;
    c0 = cyc;
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    total_cnt++;
    if (valid_cnt !== v0 || fe_cnt !== f0 || busy !== 1'b0)
      $display("FAIL glitch_quiet got v=%0d fe=%0d busy=%b exp v=%0d fe=%0d busy=0",
               valid_cnt, fe_cnt, busy, v0, f0);
    else pass_cnt++;
    total_cnt++;
    if (busy_rise_cyc !== c0 + 3 || busy_fall_cyc !== c0 + 11)
      $display("FAIL glitch_abort got=%0d..%0d exp=%0d..%0d",
               busy_rise_cyc, busy_fall_cyc, c0 + 3, c0 + 11);
    else pass_cnt++;
    exp_q.push_back('{8'h3C, 1'b0});
    send_frame(8'h3C, 1'b1);
    idle(20);
    total_cnt++;
    if (valid_cnt !== v0 + 1)
      $display("FAIL glitch_next got=%0d exp=%0d", valid_cnt, v0 + 1);
    else pass_cnt++;
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    total_cnt++;
    if (fe_cnt !== f0 + 1 || valid_cnt !== v0)
      $display("FAIL ferr_count got fe=%0d v=%0d exp fe=%0d v=%0d",
               fe_cnt, valid_cnt, f0 + 1, v0);
    else pass_cnt++;
    total_cnt++;
    if (last_fe_cyc !== frame_c0 + 155)
      $display("FAIL ferr_time got=%0d exp=%0d", last_fe_cyc, frame_c0 + 155);
    else pass_cnt++;
    total_cnt++;
    if (rx_byte !== 8'h3C)
      $display("FAIL ferr_hold got=%h exp=3c", rx_byte);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL ferr_wait got busy=%b exp=1", busy);
    else pass_cnt++;
    idle(20);
    total_cnt++;
    if (busy !== 1'b0 || fe_cnt !== f0 + 1)
      $display("FAIL ferr_release got busy=%b fe=%0d exp busy=0 fe=%0d",
               busy, fe_cnt, f0 + 1);
    else pass_cnt++;
    exp_q.push_back('{8'h81, 1'b0});
    send_frame(8'h81, 1'b1);
    idle(20);
    total_cnt++;
    if (valid_cnt !== v0 + 1)
      $display("FAIL ferr_next got=%0d exp=%0d", valid_cnt, v0 + 1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    vcyc_q.delete();
    exp_q.push_back('{8'h00, 1'b0});
    exp_q.push_back('{8'hFF, 1'b0});
    exp_q.push_back('{8'h55, 1'b0});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(20);
    total_cnt++;
    if (valid_cnt !== v0 + 3)
      $display("FAIL b2b_count got=%0d exp=%0d", valid_cnt, v0 + 3);
    else pass_cnt++;
    total_cnt++;
    if (vcyc_q.size() != 3)
      $display("FAIL b2b_spacing got %0d pulses exp 3", vcyc_q.size());
    else if (vcyc_q[1] - vcyc_q[0] != 160 || vcyc_q[2] - vcyc_q[1] != 160)
      $display("FAIL b2b_spacing got=%0d,%0d exp=160,160",
               vcyc_q[1] - vcyc_q[0], vcyc_q[2] - vcyc_q[1]);
    else pass_cnt++;
  endtask

  task automatic test_overrun;
    int v0, o0;
    v0 = valid_cnt; o0 = ovr_cnt;
    fifo_full = 1'b1;
    exp_q.push_back('{8'h7E, 1'b1});
    send_frame(8'h7E, 1'b1);
    idle(20);
    fifo_full = 1'b0;
    total_cnt++;
    if (ovr_cnt !== o0 + 1 || valid_cnt !== v0 + 1)
      $display("FAIL ovr_full got ovr=%0d v=%0d exp ovr=%0d v=%0d",
               ovr_cnt, valid_cnt, o0 + 1, v0 + 1);
    else pass_cnt++;
    exp_q.push_back('{8'h12, 1'b0});
    send_frame(8'h12, 1'b1);
    idle(20);
    total_cnt++;
    if (ovr_cnt !== o0 + 1 || valid_cnt !== v0 + 2)
      $display("FAIL ovr_clear got ovr=%0d v=%0d exp ovr=%0d v=%0d",
               ovr_cnt, valid_cnt, o0 + 1, v0 + 2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int v0, f0;
    logic [7:0] d;
    d = 8'hF0;
    v0 = valid_cnt; f0 = fe_cnt;
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx_serial = d[k];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = d[3];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if ({rx_valid, frame_error, overrun, busy} !== 4'b0000)
      $display("FAIL rmid_outputs got=%b exp=0000",
               {rx_valid, frame_error, overrun, busy});
    else pass_cnt++;
    total_cnt++;
    if (rx_byte !== 8'h00)
      $display("FAIL rmid_byte got=%h exp=00", rx_byte);
    else pass_cnt++;
    idle(200);
    total_cnt++;
    if (valid_cnt !== v0 || fe_cnt !== f0)
      $display("FAIL rmid_quiet got v=%0d fe=%0d exp v=%0d fe=%0d",
               valid_cnt, fe_cnt, v0, f0);
    else pass_cnt++;
    exp_q.push_back('{8'h5A, 1'b0});
    send_frame(8'h5A, 1'b1);
    idle(20);
    total_cnt++;
    if (valid_cnt !== v0 + 1)
      $display("FAIL rmid_next got=%0d exp=%0d", valid_cnt, v0 + 1);
    else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
